// File: rtl/raster_framebuffer_scanner.sv
// raster_framebuffer_scanner: walks one frame in raster order and turns one-cycle-latency RAM reads into a tagged pixel stream.
// Optional SCANNER_SERPENTINE_EN: odd lines are read right to left.
module raster_framebuffer_scanner #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] fb_address,
    output logic              fb_chipselect,
    output logic              fb_clken,
    output logic              fb_write,
    input  logic [DATA_W-1:0] fb_readdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy
);
    localparam int XW = $clog2(WIDTH > 1 ? WIDTH : 2);
    localparam int YW = $clog2(HEIGHT > 1 ? HEIGHT : 2) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t              r_state;
    logic [XW-1:0]       r_x;
    logic [YW-1:0]       r_y;
    logic [ADDR_W-1:0]   r_line_base;
    logic                r_inflight;
    logic [2:0]          r_tag;
    logic [DATA_W+2:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic                w_last_x, w_last_y, w_issue, w_pop;
    logic [2:0]          w_tag;
    logic [DATA_W+2:0]   w_head;

    assign w_last_x = r_x == XW'(WIDTH - 1);
    assign w_last_y = r_y == YW'(HEIGHT - 1);
    // credit check counts the read in flight so a landing word always has a slot
    assign w_issue  = r_state == SCAN && enable && (r_count + CW'(r_inflight) < CW'(FIFO_DEPTH));
    assign w_tag    = {w_last_x && w_last_y, w_last_x, r_x == '0 && r_y == '0};

`ifdef SCANNER_SERPENTINE_EN
    assign fb_address = r_y[0] ? r_line_base + ADDR_W'(WIDTH - 1) - ADDR_W'(r_x)
                               : r_line_base + ADDR_W'(r_x);
`else
    assign fb_address = r_line_base + ADDR_W'(r_x);
`endif

    assign fb_chipselect = w_issue;
    assign fb_clken      = w_issue;
    assign fb_write      = 1'b0;
    assign busy          = r_state != IDLE;

    assign w_head    = r_mem[r_rd_ptr];
    assign pix_valid = r_count != '0;
    assign w_pop     = pix_valid && pix_ready;
    assign pix_data  = pix_valid ? w_head[DATA_W-1:0] : '0;
    assign pix_sof   = pix_valid && w_head[DATA_W];
    assign pix_eol   = pix_valid && w_head[DATA_W+1];
    assign pix_eof   = pix_valid && w_head[DATA_W+2];

    always_ff @(posedge clk) begin
        if (r_inflight) r_mem[r_wr_ptr] <= {r_tag, fb_readdata};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_line_base <= '0;
            r_inflight  <= 1'b0;
            r_tag       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) r_tag <= w_tag;
            if (r_inflight) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(r_inflight) - CW'(w_pop);
            case (r_state)
                IDLE: if (frame_start && enable) begin
                    r_state     <= SCAN;
                    r_x         <= '0;
                    r_y         <= '0;
                    r_line_base <= '0;
                end
                SCAN: if (w_issue) begin
                    if (w_last_x) begin
                        r_x         <= '0;
                        r_y         <= r_y + 1'b1;
                        r_line_base <= r_line_base + ADDR_W'(WIDTH);
                        if (w_last_y) r_state <= DRAIN;
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
                // the eof pixel is always the last FIFO entry, so its acceptance empties the pipe
                DRAIN: if (w_pop && w_head[DATA_W+2]) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_raster_framebuffer_scanner.sv
// tb_raster_framebuffer_scanner: randomized and directed checks of the scanner against a frame-level scoreboard.
module tb_raster_framebuffer_scanner;
    localparam int W = 4, H = 3, AW = 10, DW = 8, D = 4, N = W * H;

    logic clk = 0, reset_n = 0, enable = 0, frame_start = 0, pix_ready = 0;
    logic [AW-1:0] fb_address;
    logic fb_chipselect, fb_clken, fb_write;
    logic [DW-1:0] fb_readdata = '0, pix_data;
    logic pix_valid, pix_sof, pix_eol, pix_eof, busy;

    int n_tests = 0, n_fail = 0, cyc = 0, n_issued = 0, outstanding = 0, n_frames = 0;
    int base, bi, bf;
    int order[N];
    int rec_cyc[$];
    logic [DW+2:0] exp_pix[$], rec[$], head, prev_head;
    logic [AW-1:0] exp_addr[$];
    bit exp_busy = 0, stall = 0, was_busy;

    raster_framebuffer_scanner #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .frame_start(frame_start),
        .fb_address(fb_address), .fb_chipselect(fb_chipselect), .fb_clken(fb_clken), .fb_write(fb_write),
        .fb_readdata(fb_readdata), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof), .busy(busy)
    );

    always #5 clk = ~clk;

    // framebuffer preloaded with data = address, one-cycle read latency
    always @(posedge clk) begin
        if (fb_clken && fb_chipselect) fb_readdata <= DW'(fb_address);
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got unexpected activity, expected none (t=%0t)", name, $time);
    endtask

    task automatic load_frame();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                int a;
                a = y * W + x;
`ifdef SCANNER_SERPENTINE_EN
                if (y % 2 == 1) a = y * W + (W - 1 - x);
`endif
                exp_addr.push_back(AW'(a));
                exp_pix.push_back({x == W - 1 && y == H - 1, x == W - 1, x == 0 && y == 0, DW'(a)});
            end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_addr.delete();
            exp_pix.delete();
            exp_busy = 0;
            stall = 0;
            outstanding = 0;
        end else begin
            was_busy = exp_busy;
            chk("busy", busy, exp_busy);
            chk("fb_write", fb_write, 0);
            chk("fb_clken", fb_clken, fb_chipselect);
            if (fb_chipselect) begin
                chk("read_while_disabled", enable, 1);
                if (exp_addr.size() == 0) fail_now("unexpected_read");
                else chk("fb_address", fb_address, exp_addr.pop_front());
                n_issued++;
                outstanding++;
            end
            head = {pix_eof, pix_eol, pix_sof, pix_data};
            if (stall) begin
                chk("stall_valid", pix_valid, 1);
                chk("stall_hold", head, prev_head);
            end
            if (pix_valid) begin
                if (exp_pix.size() == 0) fail_now("unexpected_pixel");
                else begin
                    chk("pixel", head, exp_pix[0]);
                    if (pix_ready) begin
                        if (exp_pix[0][DW+2]) begin
                            exp_busy = 0;
                            n_frames++;
                        end
                        void'(exp_pix.pop_front());
                        rec.push_back(head);
                        rec_cyc.push_back(cyc);
                        outstanding--;
                    end
                end
            end
            chk("fifo_bound", outstanding <= D, 1);
            stall = pix_valid && !pix_ready;
            prev_head = head;
            if (frame_start && enable && !was_busy) begin
                exp_busy = 1;
                load_frame();
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1;
        cycle();
        frame_start = 0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (exp_busy && k < 400) begin
            cycle();
            k++;
        end
        chk({name, "_done"}, exp_busy, 0);
    endtask

    task automatic check_frame(input string name, input int b, input bit consec);
        chk({name, "_count"}, rec.size() - b, N);
        for (int i = 0; i < N && b + i < rec.size(); i++) begin
            chk({name, "_pix"}, rec[b+i], {i == N - 1, i % W == W - 1, i == 0, DW'(order[i])});
            if (consec) chk({name, "_gap"}, rec_cyc[b+i] - rec_cyc[b], i);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_valid"}, pix_valid, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_cs"}, fb_chipselect, 0);
        chk({name, "_addr"}, fb_address, 0);
        chk({name, "_tags"}, {pix_sof, pix_eol, pix_eof}, 0);
        chk({name, "_data"}, pix_data, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
`ifdef SCANNER_SERPENTINE_EN
        order = '{0, 1, 2, 3, 7, 6, 5, 4, 8, 9, 10, 11};
`else
        order = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
`endif
        repeat (2) cycle();
        check_zero("reset");
        reset_n = 1;
        enable = 1;
        pix_ready = 1;
        cycle();

        base = rec.size();
        start_frame();
        chk("latency_c1", pix_valid, 0);
        cycle();
        chk("latency_c2", pix_valid, 0);
        cycle();
        chk("latency_c3", pix_valid, 1);
        wait_idle("linear");
        check_frame("linear", base, 1);
        chk("linear_busy_low", busy, 0);

        base = rec.size();
        frame_start = 1;
        cycle();
        frame_start = 0;
        for (int i = 1; i < 400 && exp_busy; i++) begin
            pix_ready = (i % 4 == 0) || (i % 4 == 3);
            cycle();
        end
        pix_ready = 1;
        wait_idle("backpressure");
        check_frame("backpressure", base, 0);

        base = rec.size();
        bi = n_issued;
        start_frame();
        for (int k = 0; k < 50 && n_issued - bi < 5; k++) cycle();
        enable = 0;
        repeat (10) cycle();
        chk("pause_issued", n_issued - bi, 5);
        chk("pause_landed", rec.size() - base, 5);
        enable = 1;
        #1;
        chk("resume_cs", fb_chipselect, 1);
        chk("resume_addr", fb_address, order[5]);
        wait_idle("pause");
        check_frame("pause", base, 0);

        base = rec.size();
        bi = n_issued;
        start_frame();
        repeat (3) cycle();
        start_frame();
        for (int k = 0; k < 100 && !(pix_valid && pix_eof); k++) cycle();
        start_frame();
        repeat (5) cycle();
        chk("collide_busy", busy, 0);
        chk("collide_reads", n_issued - bi, N);
        check_frame("collide", base, 1);
        base = rec.size();
        start_frame();
        wait_idle("restart");
        check_frame("restart", base, 1);

        start_frame();
        repeat (6) cycle();
        #2;
        reset_n = 0;
        #1;
        check_zero("async_reset");
        repeat (2) cycle();
        #2;
        reset_n = 1;
        cycle();
        base = rec.size();
        start_frame();
        wait_idle("post_reset");
        check_frame("post_reset", base, 1);

        bf = n_frames;
        for (int k = 0; k < 3000; k++) begin
            pix_ready = $urandom_range(0, 3) != 0;
            enable = $urandom_range(0, 7) != 0;
            frame_start = $urandom_range(0, 15) == 0;
            cycle();
        end
        frame_start = 0;
        enable = 1;
        pix_ready = 1;
        wait_idle("random");
        repeat (3) cycle();
        chk("random_drained", exp_pix.size(), 0);
        chk("random_frames", n_frames - bf > 5, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/raster_framebuffer_scanner.md
# raster_framebuffer_scanner

Read-side scan engine for the projector framebuffer. It owns the framebuffer's second port (read-only use) and walks one full frame in raster order on each frame request. It converts the RAM's fixed one-cycle read latency into a backpressured pixel stream with start-of-frame, end-of-line and end-of-frame markers. It sits between the framebuffer and the laser modulation/galvo timing logic, which pulls pixels with `pix_ready`.

## Interface
- `WIDTH`, 640: pixels per line.
- `HEIGHT`, 480: lines per frame.
- `ADDR_W`, 19: framebuffer word address width.
- `DATA_W`, 8: pixel width.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, minimum 2.

- `clk` in 1: single clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: while low, no new reads are issued; the scan position is held.
- `frame_start` in 1: one-cycle request to scan a frame.
- `fb_address` out ADDR_W: word address for framebuffer port 2.
- `fb_chipselect` out 1: read strobe.
- `fb_clken` out 1: clock enable; equals `fb_chipselect`, so the address stalls when idle.
- `fb_write` out 1: constant 0.
- `fb_readdata` in DATA_W: RAM output, valid the cycle after a read is issued.
- `pix_data` out DATA_W: pixel value at the FIFO head.
- `pix_valid` out 1: FIFO head is valid.
- `pix_ready` in 1: consumer accepts the head when `pix_valid & pix_ready`.
- `pix_sof` out 1: head is pixel (0,0).
- `pix_eol` out 1: head is the last pixel of a line.
- `pix_eof` out 1: head is the last pixel of the frame.
- `busy` out 1: high from frame acceptance until the last pixel is accepted.

## Operation
- States are IDLE, SCAN and DRAIN.
- IDLE → SCAN: on `frame_start & enable`. Clear x=0, y=0 and line_base=0.
- SCAN: issue a read when `enable` is high and `fifo_count + inflight < FIFO_DEPTH`. `inflight` is 0 or 1.
- Issued address is `line_base + x`. In serpentine mode, odd lines use `line_base + (WIDTH-1-x)` (see Configuration).
- After each issue:
  - If x < WIDTH-1, increment x.
  - Otherwise set x=0, increment y and add WIDTH to line_base. The address is incremental; there is no multiplier.
- Tags are sof, eol and eof. They are computed at issue, delayed one cycle alongside the read, and written into the FIFO with the data.
- The read that issues (WIDTH-1, HEIGHT-1) moves the FSM to DRAIN.
- DRAIN: no reads. Exit to IDLE when the FIFO is empty, inflight=0, and the eof pixel has been accepted.
- `frame_start` outside IDLE is ignored. It is not queued.
- If `frame_start` arrives in the same cycle the eof pixel is accepted, the block goes IDLE that cycle and accepts only a later request.
- `enable` low mid-frame pauses issue only. A read already in flight still lands, and the FIFO continues to drain.
- FIFO push and pop in the same cycle leaves the count unchanged. The credit check guarantees the FIFO never overflows.

## Timing
- All outputs are low/0 after reset: `fb_address` 0, `pix_valid` 0, `busy` 0, all tags 0.
- Reset asserted mid-frame aborts immediately: FIFO emptied, inflight discarded, FSM to IDLE.
- `busy` rises the cycle after the accepting `frame_start`.
- Read issue is at cycle N. `fb_readdata` is captured at the end of cycle N+1, and `pix_valid` is high at N+2. The first pixel therefore appears 3 cycles after `frame_start`.
- Steady state with `pix_ready` held high: one pixel per cycle, with no bubbles at line boundaries.
- `pix_data`/tags are stable while `pix_valid & ~pix_ready`.
- `busy` falls the cycle after the eof pixel is accepted.

## Configuration
- `SCANNER_SERPENTINE_EN` defined: odd lines (y odd) are read right to left, for bidirectional galvo sweep.
  - `pix_eol` still marks the last pixel emitted on each line, i.e. address `line_base` on odd lines.
  - `pix_sof` and `pix_eof` are unchanged in position. eof is at address `line_base` when HEIGHT is even.
- Undefined: every line is read left to right.

## Test plan
- Linear frame, WIDTH=4, HEIGHT=3, RAM preloaded with data=address, `pix_ready`=1:
  - Required: 12 pixels 0..11 on consecutive cycles.
  - sof on 0, eol on 3/7/11, eof on 11.
  - `busy` low 1 cycle after pixel 11.
- Backpressure, same setup, `pix_ready` toggled 1,0,0,1 repeating:
  - Required: same 12-value sequence, no loss or duplication.
  - FIFO count never exceeds 4.
  - `pix_data` held stable while stalled.
- Serpentine, macro defined, WIDTH=4, HEIGHT=2:
  - Required output 0,1,2,3,7,6,5,4.
  - eol on 3 and 4, eof on 4.
- Enable pause: drop `enable` after 5 reads issued, hold 10 cycles, then restore.
  - No `fb_chipselect` during the pause; the in-flight read still emerges.
  - Resume at address 5, full sequence intact.
- Request collisions: `frame_start` pulsed mid-frame, then again in the eof acceptance cycle.
  - Both are ignored and exactly one frame is emitted.
  - A later pulse starts a new frame with sof at address 0.
- Async reset: assert `reset_n`=0 mid-frame, between clock edges.
  - Outputs go 0 immediately.
  - After release, `frame_start` produces a clean frame from address 0.
